// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
//
// Contents:
//   N_REQ        number of requesters (fixed at 8, matches the 8x3 encoder)
//   IDX_W        width of a requester index
//   DEF_MAX_HOLD default grant duration limit for the optional hold timeout
//   state_t      arbiter FSM state
//   idx_inc      modulo-8 index increment used for the priority pointer
package arb_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width is exactly log2(N_REQ), so natural overflow gives the 7->0 wrap.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first set request bit scanning upward
// from ptr, wrapping 7->0. Purely combinational.
//
// Ports:
//   req     in   [7:0]  request vector
//   ptr     in   [2:0]  index with highest priority
//   onehot  out  [7:0]  one-hot winner, zero when no request
//   idx     out  [2:0]  winner index (don't-care when any == 0)
//   any     out         at least one request is set
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pos;

    always_comb begin
        // Rotate so that bit ptr lands at position 0; a plain lowest-set-bit
        // search on the rotated vector is then the round-robin search.
        rot = N_REQ'({req, req} >> ptr);
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
        any    = |req;
        idx    = ptr + pos;
        onehot = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin 8-requester arbiter with registered one-hot grant and a
// hold/release handshake. The grant vector feeds an 8x3 encoder directly, so
// it is only ever one-hot or all-zero, and every grant is followed by at
// least one all-zero cycle.
//
// Optional feature: define HOLD_TIMEOUT_EN to add a hold limit of MAX_HOLD
// cycles (legal 1..255) and the timeout pulse output.
//
// Ports:
//   clk          in        rising-edge clock
//   rst          in        asynchronous active-high reset
//   req          in  [7:0] request vector
//   done         in        owner releases the grant (looked at only in BUSY)
//   grant        out [7:0] registered one-hot grant, 8'h00 when idle
//   grant_valid  out       grant != 0
//   timeout      out       one-cycle pulse on forced release (HOLD_TIMEOUT_EN only)
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no owner, grant=0; picks a winner from ptr on the next edge
// BUSY  | grant held for owner_q until done, request drop (or hold limit)
module rr_arbiter_8
    import arb_pkg::*;
`ifdef HOLD_TIMEOUT_EN
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
`ifdef HOLD_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             grant_valid
);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             release_req;

`ifdef HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // done and a dropped owner request in the same cycle are one release.
    assign release_req = done | ~req[owner_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef HOLD_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    state_d = BUSY;
`ifdef HOLD_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (release_req) begin
                    grant_d = '0;
                    ptr_d   = idx_inc(owner_q);
                    state_d = IDLE;
`ifdef HOLD_TIMEOUT_EN
                end else if (hold_q == HOLD_LAST) begin
                    // Forced release; a normal release above wins and keeps timeout low.
                    grant_d   = '0;
                    ptr_d     = idx_inc(owner_q);
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
`ifdef HOLD_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
`ifdef HOLD_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
`ifdef HOLD_TIMEOUT_EN
    assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

    localparam int TB_MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
`ifdef HOLD_TIMEOUT_EN
    logic       timeout;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef HOLD_TIMEOUT_EN
    rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .timeout(timeout), .grant_valid(grant_valid)
    );
`else
    rr_arbiter_8 dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid)
    );
`endif

    // Reference model: ownership as plain integers, search by modular scan.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_age;
    logic [7:0] m_grant;
    bit         m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] enc8x3(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic void model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_age   = 0;
        m_grant = 8'h00;
        m_to    = 0;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input logic d);
        m_to = 0;
        if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                int j = (m_ptr + k) % 8;
                if (r[j]) begin
                    m_busy  = 1;
                    m_owner = j;
                    m_age   = 0;
                    m_grant = 8'(1 << j);
                    break;
                end
            end
        end else if (d || !r[m_owner]) begin
            m_busy  = 0;
            m_grant = 8'h00;
            m_ptr   = (m_owner + 1) % 8;
        end else begin
`ifdef HOLD_TIMEOUT_EN
            if (m_age == TB_MAX_HOLD - 1) begin
                m_busy  = 0;
                m_grant = 8'h00;
                m_ptr   = (m_owner + 1) % 8;
                m_to    = 1;
            end else begin
                m_age++;
            end
`endif
        end
    endfunction

    // Drive inputs, take one rising edge, then compare at the falling edge.
    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
        chk("model_grant", grant, m_grant);
        chk("grant_valid", {7'b0, grant_valid}, {7'b0, (m_grant != 8'h00)});
        chk("popcount_le1", {7'b0, ($countones(grant) <= 1)}, 8'h01);
`ifdef HOLD_TIMEOUT_EN
        chk("timeout", {7'b0, timeout}, {7'b0, m_to});
`endif
    endtask

    initial begin
        // Rotation with req=FF, done asserted the cycle after each grant.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back('{8'hFF, 1'b0, 8'(1 << i)});
            tbl.push_back('{8'hFF, 1'b1, 8'h00});
        end
        tbl.push_back('{8'hFF, 1'b0, 8'h01});  // wrap 7->0
        tbl.push_back('{8'hFF, 1'b1, 8'h00});  // ptr=1
        // Request-drop release, then wrap search from ptr=5.
        tbl.push_back('{8'h10, 1'b0, 8'h10});
        tbl.push_back('{8'h00, 1'b0, 8'h00});  // ptr=5
        tbl.push_back('{8'h11, 1'b0, 8'h01});
        tbl.push_back('{8'h11, 1'b1, 8'h00});  // ptr=1
        // Simultaneous done and request drop for owner 2.
        tbl.push_back('{8'h04, 1'b0, 8'h04});
        tbl.push_back('{8'h00, 1'b1, 8'h00});  // single release, ptr=3
        tbl.push_back('{8'h0C, 1'b0, 8'h08});
        tbl.push_back('{8'h0C, 1'b1, 8'h00});  // ptr=4

        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_grant", grant, 8'h00);
        chk("reset_valid", {7'b0, grant_valid}, 8'h00);
        rst = 1'b0;
        step(8'h00, 1'b1);
        chk("idle_no_req", grant, 8'h00);

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].done);
            chk($sformatf("vec%0d", i), grant, tbl[i].exp);
        end

        // Hold stability: owner 2 with other requests toggling, no done.
        step(8'h04, 1'b0);
        chk("hold_acquire", grant, 8'h04);
        for (int i = 0; i < 12; i++) begin
            step(8'($urandom) | 8'h04, 1'b0);
            chk("hold_stable", grant, 8'h04);
            chk("hold_enc", {5'b0, enc8x3(grant)}, 8'h02);
        end
        step(8'hFF, 1'b1);
        chk("hold_release", grant, 8'h00);  // ptr=3

        // Asynchronous reset while grant=8'h08.
        step(8'h08, 1'b0);
        chk("pre_reset_grant", grant, 8'h08);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_grant", grant, 8'h00);
        chk("async_reset_valid", {7'b0, grant_valid}, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(8'h81, 1'b0);
        chk("post_reset_ptr0", grant, 8'h01);
        step(8'h81, 1'b1);
        chk("post_reset_rel", grant, 8'h00);

        // Lone requester with done held: grant, gap, grant, gap.
        for (int i = 0; i < 4; i++) begin
            step(8'h20, 1'b1);
            chk("lone_req", grant, (i % 2 == 0) ? 8'h20 : 8'h00);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom) & 8'($urandom), ($urandom_range(0, 3) == 0));
        end

`ifdef HOLD_TIMEOUT_EN
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'h02, 1'b0);
            chk("to_hold", grant, 8'h02);
        end
        step(8'h02, 1'b0);
        chk("to_gap", grant, 8'h00);
        chk("to_pulse", {7'b0, timeout}, 8'h01);
        step(8'h02, 1'b0);
        chk("to_regrant", grant, 8'h02);
        chk("to_pulse_end", {7'b0, timeout}, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
